axis_byte_compactor: RTL and testbench

- Parametrised successor of the U-plane tkeep cleaner.
- Removes null bytes (TKEEP=0) from an AXI4-Stream and packs the valid bytes densely into full-width beats at any DATA_WIDTH.
- A segment closes on slave_TUSER, and optionally on slave_TLAST. At segment close the residue is flushed as a final partial beat.
- Fully pipelined under backpressure, with no throughput loss. Sits between the U-plane section builder and the Ethernet framer.

---
 rtl/axis_byte_compactor.sv | 137 +++++++++++++
 tb/tb_axis_byte_compactor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_byte_compactor.sv
// axis_byte_compactor: strips null bytes from an AXI4-Stream and packs the kept bytes into dense full-width beats.
// Define SPARSE_KEEP_EN to accept arbitrary TKEEP; otherwise TKEEP must be contiguous from bit 0 and err_keep flags violations.
module axis_byte_compactor #(
  parameter int DATA_WIDTH = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int FLUSH_ON_TLAST = 0,
  localparam int KB = DATA_WIDTH / 8,
  localparam int FW = $clog2(KB) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] slave_TDATA,
  input  logic [KB-1:0]         slave_TKEEP,
  input  logic                  slave_TVALID,
  input  logic                  slave_TLAST,
  input  logic                  slave_TUSER,
  output logic                  slave_TREADY,
  output logic [DATA_WIDTH-1:0] master_TDATA,
  output logic [KB-1:0]         master_TKEEP,
  output logic                  master_TVALID,
  output logic                  master_TLAST,
  output logic                  master_TUSER,
  input  logic                  master_TREADY,
`ifndef SPARSE_KEEP_EN
  output logic                  err_keep,
`endif
  output logic [FW-1:0]         dbg_fill
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + KB + 2;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_WIDTH-1:0] acc, acc_n, packed_d;
  logic [2*DATA_WIDTH-1:0] wide;
  logic [FW-1:0] fill, fill_n, n, new_fill, rem;
  logic [KB-1:0] mask_new, mask_rem;
  logic [EW-1:0] e0, e1;
  logic [1:0] np;
  logic tlast_flag, flag_n, accept, close, last_out, pop;
  assign accept = slave_TVALID & slave_TREADY;
`ifdef SPARSE_KEEP_EN
  // Prefix-sum lane mux: the running count of kept lanes is each byte's destination.
  always_comb begin
    packed_d = '0;
    n = '0;
    for (int i = 0; i < KB; i++)
      if (slave_TKEEP[i]) begin
        packed_d[n*8 +: 8] = slave_TDATA[i*8 +: 8];
        n = n + FW'(1);
      end
  end
`else
  logic contig;
  logic [KB-1:0] keep_eff;
  assign contig = ~|(slave_TKEEP & (slave_TKEEP + KB'(1)));
  assign keep_eff = contig ? slave_TKEEP : '0;
  always_comb begin
    packed_d = '0;
    n = '0;
    for (int i = 0; i < KB; i++) begin
      packed_d[i*8 +: 8] = keep_eff[i] ? slave_TDATA[i*8 +: 8] : 8'h00;
      n = n + FW'(keep_eff[i]);
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) err_keep <= 1'b0;
    else if (accept && !contig) err_keep <= 1'b1;
`endif
  // Bytes of acc above fill are always zero, so OR-ing in the shifted beat appends it.
  assign wide = {{DATA_WIDTH{1'b0}}, acc} | ({{DATA_WIDTH{1'b0}}, packed_d} << {fill, 3'b000});
  assign new_fill = fill + n;
  assign rem = new_fill - FW'(KB);
  assign close = slave_TUSER | ((FLUSH_ON_TLAST != 0) & slave_TLAST);
  assign last_out = tlast_flag | slave_TLAST;
  always_comb begin
    mask_new = '0;
    mask_rem = '0;
    for (int i = 0; i < KB; i++) begin
      mask_new[i] = i < int'(new_fill);
      mask_rem[i] = i < int'(rem);
    end
  end
  always_comb begin
    e0 = {1'b0, 1'b0, {KB{1'b1}}, wide[DATA_WIDTH-1:0]};
    e1 = {last_out, 1'b1, mask_rem, wide[2*DATA_WIDTH-1:DATA_WIDTH]};
    np = 2'd0;
    acc_n = acc;
    fill_n = fill;
    flag_n = tlast_flag;
    if (accept) begin
      flag_n = close ? 1'b0 : last_out;
      if (close) begin
        acc_n = '0;
        fill_n = '0;
        np = (new_fill > FW'(KB)) ? 2'd2 : 2'd1;
        if (new_fill <= FW'(KB)) e0 = {last_out, 1'b1, mask_new, wide[DATA_WIDTH-1:0]};
      end else if (new_fill >= FW'(KB)) begin
        np = 2'd1;
        acc_n = wide[2*DATA_WIDTH-1:DATA_WIDTH];
        fill_n = rem;
      end else begin
        acc_n = wide[DATA_WIDTH-1:0];
        fill_n = new_fill;
      end
    end
  end
  assign pop = master_TVALID & master_TREADY;
  assign master_TVALID = cnt != '0;
  assign cnt_n = cnt + CW'(np) - CW'(pop);
  assign {master_TLAST, master_TUSER, master_TKEEP, master_TDATA} = master_TVALID ? mem[rd_ptr] : '0;
  assign dbg_fill = fill;
  always_ff @(posedge clk) begin
    if (np != 2'd0) mem[wr_ptr] <= e0;
    if (np == 2'd2) mem[wr_ptr + AW'(1)] <= e1;
  end
  // Ready is registered from the next-cycle occupancy so two free slots are guaranteed on accept.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      acc <= '0;
      fill <= '0;
      tlast_flag <= 1'b0;
      slave_TREADY <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(np);
      rd_ptr <= rd_ptr + AW'(pop);
      cnt <= cnt_n;
      acc <= acc_n;
      fill <= fill_n;
      tlast_flag <= flag_n;
      slave_TREADY <= cnt_n <= CW'(FIFO_DEPTH - 2);
    end
endmodule

// File: tb/tb_axis_byte_compactor.sv
// tb_axis_byte_compactor: vector table plus byte-queue scoreboard for axis_byte_compactor at DATA_WIDTH=128.
module tb_axis_byte_compactor;
  localparam int DW = 128;
  localparam int KB = 16;
  logic clk = 1'b0, reset = 1'b1;
  logic [DW-1:0] slave_TDATA, master_TDATA;
  logic [KB-1:0] slave_TKEEP, master_TKEEP;
  logic slave_TVALID, slave_TLAST, slave_TUSER, slave_TREADY;
  logic master_TVALID, master_TLAST, master_TUSER, master_TREADY;
  logic [4:0] dbg_fill;
`ifndef SPARSE_KEEP_EN
  logic err_keep;
`endif
  axis_byte_compactor #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .FLUSH_ON_TLAST(0)) dut (
    .clk(clk), .reset(reset),
    .slave_TDATA(slave_TDATA), .slave_TKEEP(slave_TKEEP), .slave_TVALID(slave_TVALID),
    .slave_TLAST(slave_TLAST), .slave_TUSER(slave_TUSER), .slave_TREADY(slave_TREADY),
    .master_TDATA(master_TDATA), .master_TKEEP(master_TKEEP), .master_TVALID(master_TVALID),
    .master_TLAST(master_TLAST), .master_TUSER(master_TUSER), .master_TREADY(master_TREADY),
`ifndef SPARSE_KEEP_EN
    .err_keep(err_keep),
`endif
    .dbg_fill(dbg_fill)
  );
  always #5 clk = ~clk;
  typedef struct { logic [DW-1:0] d; logic [KB-1:0] k; logic u; logic l; } beat_t;
  typedef struct { logic [KB-1:0] k; logic u; logic l; logic [4:0] fill; } vec_t;
  beat_t sb[$];
  beat_t exp_b, prev;
  logic [7:0] mq[$];
  logic mflag = 1'b0;
  logic [7:0] seq = 8'd0;
  logic prev_stall = 1'b0;
  logic rand_rdy = 1'b0;
  int checks = 0, failures = 0;
  vec_t vt[12];

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic emit(input int cnt, input logic u, input logic l);
    beat_t b;
    b.d = '0;
    b.k = '0;
    b.u = u;
    b.l = l;
    for (int i = 0; i < cnt; i++) begin
      b.d[i*8 +: 8] = mq.pop_front();
      b.k[i] = 1'b1;
    end
    sb.push_back(b);
  endtask

  // Reference: a plain byte queue, cut into beats whenever a full beat or a segment close is available.
  task automatic model_accept(input logic [DW-1:0] d, input logic [KB-1:0] k, input logic u, input logic l);
    logic [KB-1:0] ke;
    ke = k;
`ifndef SPARSE_KEEP_EN
    if ((k & (k + 16'd1)) != 16'd0) ke = '0;
`endif
    for (int i = 0; i < KB; i++)
      if (ke[i]) mq.push_back(d[i*8 +: 8]);
    mflag = mflag | l;
    if (!u) begin
      if (mq.size() >= KB) emit(KB, 1'b0, 1'b0);
    end else begin
      if (mq.size() > KB) emit(KB, 1'b0, 1'b0);
      emit(mq.size(), 1'b1, mflag);
      mflag = 1'b0;
    end
  endtask

  task automatic send(input logic [KB-1:0] k, input logic u, input logic l);
    int t;
    t = 0;
    for (int i = 0; i < KB; i++)
      if (k[i]) begin
        slave_TDATA[i*8 +: 8] = seq;
        seq = seq + 8'd1;
      end else slave_TDATA[i*8 +: 8] = 8'($urandom);
    slave_TKEEP = k;
    slave_TUSER = u;
    slave_TLAST = l;
    slave_TVALID = 1'b1;
    while (!slave_TREADY && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready", slave_TREADY, 1);
    if (!slave_TREADY) begin
      slave_TVALID = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(slave_TDATA, k, u, l);
    @(negedge clk);
    slave_TVALID = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("stall_valid", master_TVALID, 1);
        chk("stall_hold", {master_TLAST, master_TUSER, master_TKEEP, master_TDATA}, {prev.l, prev.u, prev.k, prev.d});
      end
      if (master_TVALID && master_TREADY) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_beat: got keep %h data %h, required no beat", master_TKEEP, master_TDATA);
        end else begin
          exp_b = sb.pop_front();
          chk("out_data", master_TDATA, exp_b.d);
          chk("out_keep", master_TKEEP, exp_b.k);
          chk("out_user", master_TUSER, exp_b.u);
          chk("out_last", master_TLAST, exp_b.l);
        end
      end
      prev_stall = master_TVALID && !master_TREADY;
      prev = '{master_TDATA, master_TKEEP, master_TUSER, master_TLAST};
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) master_TREADY = 1'($urandom_range(0, 1));
  end

  initial begin
    logic [KB-1:0] k;
    int nb;
    vt[0]  = '{16'h00FF, 1'b0, 1'b0, 5'd8};
    vt[1]  = '{16'h00FF, 1'b0, 1'b0, 5'd0};
    vt[2]  = '{16'h00FF, 1'b0, 1'b0, 5'd8};
    vt[3]  = '{16'h00FF, 1'b1, 1'b0, 5'd0};
    vt[4]  = '{16'h0000, 1'b1, 1'b0, 5'd0};
    vt[5]  = '{16'h0003, 1'b0, 1'b1, 5'd2};
    vt[6]  = '{16'h000F, 1'b0, 1'b0, 5'd6};
    vt[7]  = '{16'h0001, 1'b1, 1'b0, 5'd0};
    vt[8]  = '{16'h0000, 1'b0, 1'b0, 5'd0};
    vt[9]  = '{16'hFFFF, 1'b0, 1'b0, 5'd0};
    vt[10] = '{16'h7FFF, 1'b0, 1'b0, 5'd15};
    vt[11] = '{16'hFFFF, 1'b1, 1'b1, 5'd0};
    slave_TDATA = '0;
    slave_TKEEP = '0;
    slave_TVALID = 1'b0;
    slave_TLAST = 1'b0;
    slave_TUSER = 1'b0;
    master_TREADY = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mvalid", master_TVALID, 0);
    chk("rst_sready", slave_TREADY, 0);
    chk("rst_fill", dbg_fill, 0);
    chk("rst_mdata", {master_TLAST, master_TUSER, master_TKEEP, master_TDATA}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", slave_TREADY, 1);
    for (int i = 0; i < 12; i++) begin
      send(vt[i].k, vt[i].u, vt[i].l);
      chk($sformatf("vec%0d_fill", i), dbg_fill, vt[i].fill);
    end
    drain();
    // Two 12-byte beats with close: full beat then 8-byte tail on consecutive cycles.
    send(16'h0FFF, 1'b0, 1'b0);
    chk("dbl_fill", dbg_fill, 12);
    send(16'h0FFF, 1'b1, 1'b0);
    chk("dbl_first_valid", master_TVALID, 1);
    chk("dbl_first_keep", master_TKEEP, 16'hFFFF);
    chk("dbl_first_user", master_TUSER, 0);
    chk("dbl_fill0", dbg_fill, 0);
    @(negedge clk);
    chk("dbl_second_valid", master_TVALID, 1);
    chk("dbl_second_keep", master_TKEEP, 16'h00FF);
    chk("dbl_second_user", master_TUSER, 1);
    drain();
    // Mid-segment reset discards the held 9 bytes.
    send(16'h01FF, 1'b0, 1'b0);
    chk("pre_reset_fill", dbg_fill, 9);
    reset = 1'b1;
    #1;
    chk("mid_rst_mvalid", master_TVALID, 0);
    chk("mid_rst_sready", slave_TREADY, 0);
    chk("mid_rst_fill", dbg_fill, 0);
    chk("mid_rst_mdata", {master_TLAST, master_TUSER, master_TKEEP, master_TDATA}, 0);
    mq.delete();
    sb.delete();
    mflag = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_mid_reset", slave_TREADY, 1);
    send(16'h000F, 1'b1, 1'b0);
    drain();
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
`ifdef SPARSE_KEEP_EN
      k = 16'($urandom);
`else
      nb = $urandom_range(0, 16);
      k = (nb == 16) ? 16'hFFFF : 16'((32'd1 << nb) - 1);
`endif
      send(k, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end
    send(16'h0000, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rand_rdy = 1'b0;
    master_TREADY = 1'b1;
    @(negedge clk);
    drain();
    chk("final_fill", dbg_fill, 0);
`ifndef SPARSE_KEEP_EN
    chk("err_keep_clear", err_keep, 0);
    send(16'h00F0, 1'b1, 1'b0);
    drain();
    chk("err_keep_set", err_keep, 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
